ar_sequencer: RTL and testbench
===============================

Name: ar_sequencer

Overview:
Multi-cycle controller that sequences the AR-type datapath (control unit, ALU control, ALU, register file). It owns the PC and instruction register, fetches over a req/ready handshake to instruction memory, and drives the ALU-enable and register-file write strobe one phase at a time. The processor top instantiates it and feeds its instruction register output to the decode path in place of a free-running instruction wire.

Parameters:
PC_WIDTH, 32, width of PC and imem_addr
PC_STEP, 4, PC increment per retired instruction
RESET_PC, 0, PC value after reset
AR_OPCODE, 5'b00000, instr[31:27] value for AR-type instructions
HALT_OPCODE, 5'b11111, instr[31:27] value for HALT

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-low reset
start  input  1  leaves IDLE; resumes from HALTED
imem_req  output  1  fetch request, held until accepted
imem_addr  output  PC_WIDTH  fetch address (= pc)
imem_ready  input  1  memory has imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
instr  output  32  instruction register (opcode [31:27], func [26:23], rs1 [22:19], rs2 [18:15], rd [14:11])
alu_en  output  1  high during EXEC
regWrite  output  1  register file write strobe, high during WB only
pc  output  PC_WIDTH  current PC
instr_count  output  32  retired-instruction counter
halted  output  1  in HALTED state
illegal  output  1  in TRAP state (sticky)

Behaviour:
- Reset (RESET low, async): state=IDLE, pc=RESET_PC, instr=0, instr_count=0. All strobes (imem_req, alu_en, regWrite, halted, illegal) are 0 immediately, without waiting for a clock edge. Reset mid-WB must drop regWrite at once.
- Outputs are Moore and decoded from the registered state. imem_addr = pc continuously.
- States and transitions, evaluated at the rising edge of CLK:
  IDLE: start=1 -> FETCH; otherwise stay.
  FETCH: imem_req=1. If imem_ready=1: instr<=imem_rdata, go to DECODE. Otherwise stay, with addr stable and req held.
  DECODE: opcode==AR_OPCODE -> EXEC; opcode==HALT_OPCODE -> HALTED; any other opcode -> TRAP. Takes 1 cycle.
  EXEC: alu_en=1 for 1 cycle -> WB.
  WB: regWrite=1 for exactly 1 cycle. At the exit edge, pc<=pc+PC_STEP (mod 2^PC_WIDTH) and instr_count<=instr_count+1 (mod 2^32). Then -> FETCH.
  HALTED: halted=1. pc stays at the HALT's address; HALT is not counted. start=1 -> pc<=pc+PC_STEP, go to FETCH.
  TRAP: illegal=1. pc holds the offending address. start is ignored; only reset exits.
- Latency: 4 cycles per AR instruction when imem_ready=1 in the first FETCH cycle. Each FETCH wait cycle adds 1.
- imem_ready and imem_rdata are ignored outside FETCH. instr changes only on fetch acceptance.
- start is ignored in FETCH, DECODE, EXEC, WB and TRAP.
- regWrite and alu_en are never high simultaneously. regWrite is never high outside WB.
- PC wrap: pc=2^PC_WIDTH-PC_STEP retiring gives pc=0, with no flag.
- Counter wrap: 0xFFFFFFFF+1 gives 0.

Test Plan:
- Reset then start, memory always ready, AR word 0x00A8_8800 at addr 0 -> FETCH/DECODE/EXEC/WB take 1 cycle each; regWrite high in cycle 4 only; pc=4; instr_count=1; second imem_req at addr 4 in cycle 5.
- imem_ready held low 3 cycles at addr 4 -> imem_req and imem_addr=4 stable for 3 cycles; instr updates only on the ready cycle; instruction retires in 7 cycles total.
- HALT (0xF800_0000) at addr 8 -> halted=1, pc=8, instr_count unchanged. start pulse -> fetch at addr 12, halted=0.
- Opcode 5'b00101 at addr 12 -> illegal=1, pc=12. Further start pulses leave the state at TRAP. RESET low -> illegal=0, pc=0, IDLE.
- RESET asserted asynchronously mid-WB (between edges) -> regWrite falls at once; instr_count not incremented; all outputs at reset values.
- PC_WIDTH=8, pc=252, retire AR -> pc=0. Preload instr_count to 0xFFFFFFFF via force, retire -> instr_count=0.

Source files
------------

// File: rtl/ar_sequencer.sv
// ar_sequencer: multi-cycle FETCH/DECODE/EXEC/WB controller for AR-type datapath.
// Owns PC, instruction register and retired count; strobes are Moore outputs.
//
// Ports:
//   CLK          in   rising-edge clock
//   RESET        in   async active-low reset
//   start        in   leave IDLE / resume from HALTED
//   imem_req     out  fetch request, held until imem_ready
//   imem_addr    out  fetch address (= pc)
//   imem_ready   in   imem_rdata valid this cycle
//   imem_rdata   in   fetched instruction word
//   instr        out  instruction register
//   alu_en       out  high in EXEC
//   regWrite     out  register file write strobe, high in WB
//   pc           out  current PC
//   instr_count  out  retired-instruction counter
//   halted       out  in HALTED
//   illegal      out  in TRAP (sticky until reset)
module ar_sequencer #(
    parameter int unsigned         PC_WIDTH    = 32,
    parameter int unsigned         PC_STEP     = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [4:0]          AR_OPCODE   = 5'b00000,
    parameter logic [4:0]          HALT_OPCODE = 5'b11111
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                start,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr,
    output logic                alu_en,
    output logic                regWrite,
    output logic [PC_WIDTH-1:0] pc,
    output logic [31:0]         instr_count,
    output logic                halted,
    output logic                illegal
);

    localparam logic [PC_WIDTH-1:0] LP_STEP = PC_WIDTH'(PC_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALTED,
        S_TRAP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [31:0]         r_instr;
    logic [31:0]         r_instr_count;
    logic                w_ld_instr;
    logic                w_pc_inc;
    logic                w_cnt_inc;
    logic [4:0]          w_opcode;

    assign w_opcode    = r_instr[31:27];
    assign pc          = r_pc;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_count = r_instr_count;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_count <= '0;
        end else begin
            if (w_ld_instr) begin
                r_instr <= imem_rdata;
            end
            if (w_pc_inc) begin
                r_pc <= r_pc + LP_STEP;
            end
            if (w_cnt_inc) begin
                r_instr_count <= r_instr_count + 32'd1;
            end
        end
    end

    // Strobes decode from the registered state only, so the async reset
    // clears them without waiting for a clock edge.
    always_comb begin
        w_next     = r_state;
        w_ld_instr = 1'b0;
        w_pc_inc   = 1'b0;
        w_cnt_inc  = 1'b0;
        imem_req   = 1'b0;
        alu_en     = 1'b0;
        regWrite   = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    w_ld_instr = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_opcode == AR_OPCODE) begin
                    w_next = S_EXEC;
                end else if (w_opcode == HALT_OPCODE) begin
                    w_next = S_HALTED;
                end else begin
                    w_next = S_TRAP;
                end
            end
            S_EXEC: begin
                alu_en = 1'b1;
                w_next = S_WB;
            end
            S_WB: begin
                regWrite  = 1'b1;
                w_pc_inc  = 1'b1;
                w_cnt_inc = 1'b1;
                w_next    = S_FETCH;
            end
            S_HALTED: begin
                halted = 1'b1;
                // The HALT itself is skipped over but not counted.
                if (start) begin
                    w_pc_inc = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ar_sequencer.sv
// tb_ar_sequencer: table-driven and scoreboard bench for ar_sequencer.
// Memory model feeds fetches; retirements are checked against a queue.
module tb_ar_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        alu_en;
    logic        regWrite;
    logic [31:0] pc;
    logic [31:0] instr_count;
    logic        halted;
    logic        illegal;

    logic        rst8;
    logic        start8;
    logic        req8;
    logic [7:0]  addr8;
    logic        ready8;
    logic [31:0] rdata8;
    logic [31:0] instr8;
    logic        alu8;
    logic        rw8;
    logic [7:0]  pc8;
    logic [31:0] cnt8;
    logic        halt8;
    logic        ill8;

    always #5 CLK = ~CLK;

    ar_sequencer dut (
        .CLK(CLK), .RESET(RESET), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .alu_en(alu_en), .regWrite(regWrite),
        .pc(pc), .instr_count(instr_count),
        .halted(halted), .illegal(illegal)
    );

    ar_sequencer #(.PC_WIDTH(8)) dut8 (
        .CLK(CLK), .RESET(rst8), .start(start8),
        .imem_req(req8), .imem_addr(addr8),
        .imem_ready(ready8), .imem_rdata(rdata8),
        .instr(instr8), .alu_en(alu8), .regWrite(rw8),
        .pc(pc8), .instr_count(cnt8),
        .halted(halt8), .illegal(ill8)
    );

    typedef struct {
        logic [31:0] word;
        int          waits;
        int          cycles;
        logic [31:0] pc;
        logic [31:0] cnt;
    } vec_t;

    typedef struct {
        logic [31:0] w;
        logic [31:0] a;
    } exp_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        req_prev = 1'b0;
    logic [31:0] mem [64];
    int          waits_at [64];
    exp_t        sb [$];
    int          model_cnt = 0;
    int          wb_cnt = 0;
    int          alu_cnt = 0;
    int          wait_left = 0;
    logic [31:0] hold_addr = '0;
    logic [31:0] last_acc = '0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        req_prev <= imem_req;
    end

    // Monitor + instruction memory model, both sampled at the falling edge.
    always @(negedge CLK) begin
        exp_t e;
        int   idx;
        if (RESET && regWrite) begin
            chk("excl_alu_wb", {63'd0, alu_en}, 64'd0);
            chk("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wb_instr", instr, e.w);
                chk("wb_pc", pc, e.a);
                chk("wb_cnt", instr_count, model_cnt);
                model_cnt++;
            end
            wb_cnt++;
        end
        if (RESET && alu_en) begin
            alu_cnt++;
        end
        idx = int'(imem_addr[7:2]);
        if (RESET && imem_req) begin
            if (!req_prev) begin
                wait_left = waits_at[idx];
            end else begin
                chk("addr_stable", imem_addr, hold_addr);
                chk("instr_hold", instr, last_acc);
            end
            hold_addr = imem_addr;
            if (wait_left > 0) begin
                imem_ready = 1'b0;
                imem_rdata = $urandom;
                wait_left--;
            end else begin
                imem_ready = 1'b1;
                imem_rdata = mem[idx];
                last_acc   = mem[idx];
                if (mem[idx][31:27] == 5'b00000) begin
                    e.w = mem[idx];
                    e.a = imem_addr;
                    sb.push_back(e);
                end
            end
        end else begin
            imem_ready = 1'($urandom % 2);
            imem_rdata = $urandom;
        end
    end

    task automatic wait_rise(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge CLK);
            if (imem_req && !req_prev) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic clear_model();
        sb.delete();
        model_cnt = 0;
        last_acc  = '0;
    endtask

    task automatic run_row(input vec_t v, input int r);
        int t0;
        int wb0;
        int al0;
        bit ok;
        t0  = cyc;
        wb0 = wb_cnt;
        al0 = alu_cnt;
        wait_rise(30, ok);
        chk($sformatf("row%0d_next_fetch", r), {63'd0, ok}, 64'd1);
        chk($sformatf("row%0d_cycles", r), cyc - t0, v.cycles);
        chk($sformatf("row%0d_pc", r), pc, v.pc);
        chk($sformatf("row%0d_addr", r), imem_addr, v.pc);
        chk($sformatf("row%0d_cnt", r), instr_count, v.cnt);
        chk($sformatf("row%0d_wb1", r), wb_cnt - wb0, 1);
        chk($sformatf("row%0d_alu1", r), alu_cnt - al0, 1);
    endtask

    initial begin
        vec_t tbl [6];
        bit   ok;

        tbl[0] = '{32'h00A8_8800, 0, 4, 32'd4,  32'd1};
        tbl[1] = '{32'h0512_3800, 3, 7, 32'd8,  32'd2};
        tbl[2] = '{32'h07FF_F800, 0, 4, 32'd4,  32'd1};
        tbl[3] = '{32'h0080_0000, 2, 6, 32'd8,  32'd2};
        tbl[4] = '{32'h0000_0000, 1, 5, 32'd12, 32'd3};
        tbl[5] = '{32'h0448_1000, 0, 4, 32'd16, 32'd4};

        for (int i = 0; i < 64; i++) begin
            mem[i]      = 32'h0000_0000;
            waits_at[i] = 0;
        end

        RESET      = 1'b0;
        start      = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        rst8       = 1'b0;
        start8     = 1'b0;
        ready8     = 1'b1;
        rdata8     = 32'h00A8_8800;

        repeat (2) @(negedge CLK);
        chk("rst_pc", pc, 0);
        chk("rst_instr", instr, 0);
        chk("rst_cnt", instr_count, 0);
        chk("rst_strobes",
            {59'd0, imem_req, alu_en, regWrite, halted, illegal}, 0);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        chk("idle_no_req", {63'd0, imem_req}, 0);

        // Phase 1: two ARs, HALT at 8, illegal opcode at 12.
        mem[0] = tbl[0].word;  waits_at[0] = tbl[0].waits;
        mem[1] = tbl[1].word;  waits_at[1] = tbl[1].waits;
        mem[2] = 32'hF800_0000;
        mem[3] = 32'h2800_0000;
        pulse_start();
        chk("p1_first_req", {63'd0, imem_req}, 1);
        chk("p1_first_addr", imem_addr, 0);
        for (int r = 0; r < 2; r++) begin
            run_row(tbl[r], r);
        end

        repeat (2) @(negedge CLK);
        chk("halt_flag", {63'd0, halted}, 1);
        chk("halt_pc", pc, 8);
        chk("halt_cnt", instr_count, 2);
        chk("halt_instr", instr, 32'hF800_0000);
        repeat (3) @(negedge CLK);
        chk("halt_hold", {62'd0, halted, imem_req}, 64'd2);
        pulse_start();
        chk("resume_halted", {63'd0, halted}, 0);
        chk("resume_req", {63'd0, imem_req}, 1);
        chk("resume_addr", imem_addr, 12);

        repeat (2) @(negedge CLK);
        chk("trap_flag", {63'd0, illegal}, 1);
        chk("trap_pc", pc, 12);
        chk("trap_cnt", instr_count, 2);
        repeat (2) pulse_start();
        @(negedge CLK);
        chk("trap_sticky", {62'd0, illegal, imem_req}, 64'd2);
        chk("trap_pc_hold", pc, 12);
        RESET = 1'b0;
        #1;
        chk("trap_rst_ill", {63'd0, illegal}, 0);
        chk("trap_rst_pc", pc, 0);
        @(negedge CLK);
        clear_model();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        chk("trap_rst_idle", {63'd0, imem_req}, 0);

        // Phase 2: four ARs with mixed waits, then reset mid-WB.
        for (int r = 2; r < 6; r++) begin
            mem[r-2]      = tbl[r].word;
            waits_at[r-2] = tbl[r].waits;
        end
        mem[4]      = 32'h0100_0800;
        waits_at[4] = 0;
        pulse_start();
        chk("p2_first_addr", imem_addr, 0);
        for (int r = 2; r < 6; r++) begin
            run_row(tbl[r], r);
        end

        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (regWrite) begin
                ok = 1'b1;
                break;
            end
        end
        chk("midwb_reached", {63'd0, ok}, 1);
        #2;
        RESET = 1'b0;
        #1;
        chk("midwb_strobes",
            {59'd0, imem_req, alu_en, regWrite, halted, illegal}, 0);
        chk("midwb_pc", pc, 0);
        chk("midwb_instr", instr, 0);
        chk("midwb_cnt", instr_count, 0);
        @(negedge CLK);
        clear_model();
        RESET = 1'b1;

        // 8-bit PC wrap and 32-bit counter wrap.
        @(negedge CLK);
        rst8 = 1'b1;
        @(negedge CLK);
        start8 = 1'b1;
        @(negedge CLK);
        start8 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (pc8 == 8'd252) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        chk("w8_reach_252", {63'd0, ok}, 1);
        chk("w8_cnt_63", cnt8, 63);
        force dut8.r_instr_count = 32'hFFFF_FFFF;
        @(negedge CLK);
        release dut8.r_instr_count;
        chk("w8_cnt_preload", cnt8, 32'hFFFF_FFFF);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (pc8 != 8'd252) begin
                ok = 1'b1;
                break;
            end
        end
        chk("w8_retired", {63'd0, ok}, 1);
        chk("w8_pc_wrap", pc8, 0);
        chk("w8_cnt_wrap", cnt8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
